effect_chain_controller: RTL and testbench

EFFECT_CHAIN_CONTROLLER -- requirements
Module: effect_chain_controller

---
 rtl/effect_chain_controller.sv | 162 ++++++++++++++++
 tb/tb_effect_chain_controller.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/effect_chain_controller.sv
// rtl/effect_chain_controller.sv - click-free effect enable switching with fade-out/settle/fade-in
// Optional preset slots are compiled in with `define EFFECT_CHAIN_CTRL_PRESET_EN.
module effect_chain_controller #(
  parameter int RAMP_STEPS     = 64,
  parameter int SETTLE_SAMPLES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [9:0]         cmd_data,
  output logic               cmd_err,
  output logic [8:0]         enable_mask,
  output logic               global_enable,
  output logic [15:0]        fade_gain,
  input  logic signed [15:0] in_sample,
  output logic signed [15:0] out_sample,
  output logic               busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FADE_OUT = 3'd1;
  localparam logic [2:0] S_SWITCH   = 3'd2;
  localparam logic [2:0] S_SETTLE   = 3'd3;
  localparam logic [2:0] S_FADE_IN  = 3'd4;

  localparam logic [1:0] OP_SET    = 2'b00;
  localparam logic [1:0] OP_TOGGLE = 2'b01;
  localparam logic [1:0] OP_STORE  = 2'b10;
  localparam logic [1:0] OP_LOAD   = 2'b11;

  localparam logic [15:0] GAIN_UNITY  = 16'h8000;
  localparam logic [15:0] GAIN_STEP   = 16'(32768 / RAMP_STEPS);
  localparam logic [15:0] SETTLE_LAST = 16'((SETTLE_SAMPLES > 0) ? (SETTLE_SAMPLES - 1) : 0);
  localparam logic [9:0]  MASK_RESET  = 10'h200;

  logic [2:0]         state;
  logic [9:0]         target;
  logic [15:0]        settle_cnt;
  logic [9:0]         current_mask;
  logic [9:0]         cmd_target;
  logic               accept;
  logic               cmd_fade;
  logic signed [32:0] product;

`ifdef EFFECT_CHAIN_CTRL_PRESET_EN
  logic [9:0] preset [4];
`endif

  assign current_mask = {global_enable, enable_mask};
  assign cmd_ready    = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign accept       = cmd_valid && cmd_ready;

  // Gain is treated as a positive 17-bit value so 0x8000 multiplies as +1.0.
  assign product = $signed({{17{in_sample[15]}}, in_sample}) * $signed({17'b0, fade_gain});

  always_comb begin
    cmd_target = current_mask;
    cmd_fade   = 1'b0;
    case (cmd_op)
      OP_SET:    cmd_target = cmd_data;
      OP_TOGGLE: cmd_target = current_mask ^ cmd_data;
`ifdef EFFECT_CHAIN_CTRL_PRESET_EN
      OP_LOAD:   cmd_target = preset[cmd_data[1:0]];
`endif
      default:   cmd_target = current_mask;
    endcase
`ifdef EFFECT_CHAIN_CTRL_PRESET_EN
    cmd_fade = (cmd_op != OP_STORE) && (cmd_target != current_mask);
`else
    cmd_fade = !cmd_op[1] && (cmd_target != current_mask);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_FADE_IN;
      fade_gain     <= 16'h0000;
      enable_mask   <= 9'h000;
      global_enable <= 1'b1;
      out_sample    <= 16'sd0;
      cmd_err       <= 1'b0;
      settle_cnt    <= 16'h0000;
      target        <= MASK_RESET;
`ifdef EFFECT_CHAIN_CTRL_PRESET_EN
      for (int i = 0; i < 4; i++) preset[i] <= MASK_RESET;
`endif
    end else begin
      cmd_err <= 1'b0;
      if (sample_tick) out_sample <= 16'(product >>> 15);

      case (state)
        S_IDLE: begin
          if (accept) begin
`ifdef EFFECT_CHAIN_CTRL_PRESET_EN
            if (cmd_op == OP_STORE) preset[cmd_data[1:0]] <= current_mask;
`else
            if (cmd_op[1]) cmd_err <= 1'b1;
`endif
            if (cmd_fade) begin
              target <= cmd_target;
              state  <= S_FADE_OUT;
            end
          end
        end

        S_FADE_OUT: begin
          if (fade_gain == 16'h0000) begin
            state <= S_SWITCH;
          end else if (sample_tick) begin
            if (fade_gain <= GAIN_STEP) begin
              fade_gain <= 16'h0000;
              state     <= S_SWITCH;
            end else begin
              fade_gain <= fade_gain - GAIN_STEP;
            end
          end
        end

        S_SWITCH: begin
          {global_enable, enable_mask} <= target;
          settle_cnt                   <= 16'h0000;
          state                        <= S_SETTLE;
        end

        S_SETTLE: begin
          if (SETTLE_SAMPLES == 0) begin
            state <= S_FADE_IN;
          end else if (sample_tick) begin
            if (settle_cnt == SETTLE_LAST) begin
              settle_cnt <= 16'h0000;
              state      <= S_FADE_IN;
            end else begin
              settle_cnt <= settle_cnt + 16'h0001;
            end
          end
        end

        S_FADE_IN: begin
          if (fade_gain >= GAIN_UNITY) begin
            fade_gain <= GAIN_UNITY;
            state     <= S_IDLE;
          end else if (sample_tick) begin
            // Saturate at unity so the ramp can never overshoot or wrap.
            if (fade_gain >= GAIN_UNITY - GAIN_STEP) begin
              fade_gain <= GAIN_UNITY;
              state     <= S_IDLE;
            end else begin
              fade_gain <= fade_gain + GAIN_STEP;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_effect_chain_controller.sv
// tb/tb_effect_chain_controller.sv - randomized self-checking bench for effect_chain_controller
module tb_effect_chain_controller;

  localparam int RS   = 64;
  localparam int SS   = 32;
  localparam int STEP = 32768 / RS;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sample_tick = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'b00;
  logic [9:0]         cmd_data = 10'h000;
  logic               cmd_err;
  logic [8:0]         enable_mask;
  logic               global_enable;
  logic [15:0]        fade_gain;
  logic signed [15:0] in_sample = 16'sd0;
  logic signed [15:0] out_sample;
  logic               busy;

  effect_chain_controller #(.RAMP_STEPS(RS), .SETTLE_SAMPLES(SS)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_err(cmd_err), .enable_mask(enable_mask), .global_enable(global_enable),
    .fade_gain(fade_gain), .in_sample(in_sample), .out_sample(out_sample), .busy(busy)
  );

  always #5 clk = ~clk;

  int                 checks = 0;
  int                 errors = 0;
  int                 m_gain;
  logic [9:0]         m_mask;
  logic signed [15:0] m_out;
  logic [9:0]         m_preset [4];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  function automatic logic signed [15:0] pick_sample();
    if (m_gain == 32'h4000) return 16'sd1000;
    return 16'($urandom);
  endfunction

  // Reference output: real multiply of the sample by gain/32768, floored.
  task automatic do_cycle(input bit tick, input logic signed [15:0] smp);
    longint p;
    sample_tick = tick;
    in_sample   = smp;
    @(posedge clk);
    if (tick) begin
      p     = longint'(smp) * longint'(m_gain);
      m_out = 16'(p >>> 15);
    end
    #1;
    sample_tick = 1'b0;
    check_val("out_sample", {16'h0, out_sample}, {16'h0, m_out});
  endtask

  task automatic tick_with_gap();
    repeat ($urandom_range(1, 3)) do_cycle(1'b0, 16'($urandom));
    do_cycle(1'b1, pick_sample());
  endtask

  task automatic fade_in_phase();
    for (int k = 1; k <= RS; k++) begin
      tick_with_gap();
      m_gain += STEP;
      check_val("fade_in_gain", {16'h0, fade_gain}, 32'(m_gain));
      if (k < RS) check_val("fade_in_busy", {31'h0, busy}, 32'd1);
    end
    check_val("fade_in_done_busy", {31'h0, busy}, 32'd0);
    check_val("fade_in_done_ready", {31'h0, cmd_ready}, 32'd1);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    sample_tick = 1'b0;
    cmd_valid   = 1'b0;
    @(posedge clk);
    #1;
    m_gain = 0;
    m_out  = 16'sd0;
    m_mask = 10'h200;
    for (int i = 0; i < 4; i++) m_preset[i] = 10'h200;
    check_val("rst_gain", {16'h0, fade_gain}, 32'h0);
    check_val("rst_mask", {23'h0, enable_mask}, 32'h0);
    check_val("rst_global", {31'h0, global_enable}, 32'd1);
    check_val("rst_out", {16'h0, out_sample}, 32'h0);
    check_val("rst_err", {31'h0, cmd_err}, 32'd0);
    check_val("rst_busy", {31'h0, busy}, 32'd1);
    rst = 1'b0;
    fade_in_phase();
  endtask

  task automatic run_transition(input logic [9:0] tgt, input bit hold, input logic [1:0] hop,
                                input logic [9:0] hdata, input int abort_at);
    check_val("accept_busy", {31'h0, busy}, 32'd1);
    check_val("accept_ready", {31'h0, cmd_ready}, 32'd0);
    if (hold) begin
      cmd_valid = 1'b1;
      cmd_op    = hop;
      cmd_data  = hdata;
    end
    for (int k = 1; k <= RS; k++) begin
      tick_with_gap();
      m_gain -= STEP;
      check_val("fade_out_gain", {16'h0, fade_gain}, 32'(m_gain));
      check_val("fade_out_mask", {22'h0, global_enable, enable_mask}, {22'h0, m_mask});
    end
    do_cycle(1'b0, 16'($urandom));
    m_mask = tgt;
    check_val("switch_mask", {22'h0, global_enable, enable_mask}, {22'h0, m_mask});
    for (int k = 1; k <= SS; k++) begin
      tick_with_gap();
      check_val("settle_gain", {16'h0, fade_gain}, 32'h0);
      check_val("settle_busy", {31'h0, busy}, 32'd1);
      if (k == abort_at) begin
        do_reset();
        return;
      end
    end
    fade_in_phase();
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [9:0] data,
                          input bit hold = 1'b0, input logic [1:0] hop = 2'b00,
                          input logic [9:0] hdata = 10'h0, input int abort_at = 0);
    logic [9:0] tgt;
    check_val("ready_before_cmd", {31'h0, cmd_ready}, 32'd1);
    case (op)
      2'b00:   tgt = data;
      2'b01:   tgt = m_mask ^ data;
      2'b11:   tgt = m_preset[data[1:0]];
      default: tgt = m_mask;
    endcase
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    do_cycle(1'b0, 16'($urandom));
    cmd_valid = 1'b0;
`ifndef EFFECT_CHAIN_CTRL_PRESET_EN
    if (op[1]) begin
      check_val("preset_err_pulse", {31'h0, cmd_err}, 32'd1);
      check_val("preset_err_busy", {31'h0, busy}, 32'd0);
      do_cycle(1'b0, 16'($urandom));
      check_val("preset_err_clear", {31'h0, cmd_err}, 32'd0);
      check_val("preset_err_mask", {22'h0, global_enable, enable_mask}, {22'h0, m_mask});
      return;
    end
`endif
    check_val("cmd_no_err", {31'h0, cmd_err}, 32'd0);
    if (op == 2'b10) begin
      m_preset[data[1:0]] = m_mask;
      check_val("store_busy", {31'h0, busy}, 32'd0);
    end else if (tgt == m_mask) begin
      check_val("same_busy", {31'h0, busy}, 32'd0);
      check_val("same_ready", {31'h0, cmd_ready}, 32'd1);
      check_val("same_gain", {16'h0, fade_gain}, 32'h8000);
    end else begin
      run_transition(tgt, hold, hop, hdata, abort_at);
    end
  endtask

  initial begin
    m_gain = 0;
    m_out  = 16'sd0;
    m_mask = 10'h200;
    @(posedge clk);
    do_reset();

    send_cmd(2'b00, 10'h3FF);
    send_cmd(2'b00, 10'h3FF);

    do_cycle(1'b1, -16'sd32768);
    do_cycle(1'b1, 16'sd32767);

    send_cmd(2'b00, 10'h155, 1'b1, 2'b01, 10'h0F0);
    send_cmd(2'b01, 10'h0F0);

    for (int i = 0; i < 5; i++) begin
      logic [1:0] op;
      logic [9:0] data;
      op   = 2'($urandom_range(0, 3));
      data = 10'($urandom);
      if ($urandom_range(0, 3) == 0 && op == 2'b00) data = m_mask;
      send_cmd(op, data);
    end

    send_cmd(2'b10, 10'd2);
    send_cmd(2'b00, m_mask ^ 10'h0A5);
    send_cmd(2'b11, 10'd2);

    send_cmd(2'b00, m_mask ^ 10'h00F, 1'b0, 2'b00, 10'h0, 10);
    send_cmd(2'b01, 10'h101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
